// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

  localparam int MDU_N = 32;

  // op[1] selects divide, op[0] selects signed
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MDU_N);

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between control and the multiply/divide unit.
// Latency: none (wiring only).
// Backpressure: control must hold off on busy; start/mthi/mtlo are ignored while busy.
interface mult_div_unit_if #(parameter int N = 32);
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] src_a;
  logic [N-1:0] src_b;
  logic         mthi;
  logic         mtlo;
  logic [N-1:0] wdata;
  logic         rd_sel;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [N-1:0] rd_data;

  modport master (
    output start, op, src_a, src_b, mthi, mtlo, wdata, rd_sel,
    input  busy, done, hi, lo, rd_data
  );

  modport slave (
    input  start, op, src_a, src_b, mthi, mtlo, wdata, rd_sel,
    output busy, done, hi, lo, rd_data
  );
endinterface

// File: rtl/mdu_datapath.sv
// Magnitude shift-add multiplier / restoring divider with sign fix-up of the final result.
// Latency: one step per i_step; o_res_* valid combinationally after N steps.
// Backpressure: none; the controlling FSM sequences i_load and i_step.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_src_a,
  input  logic [N-1:0] i_src_b,
  output logic [N-1:0] o_res_hi,
  output logic [N-1:0] o_res_lo
);

  // r_acc: product high half / partial remainder; r_q: multiplier / dividend->quotient
  logic [N-1:0] r_acc;
  logic [N-1:0] r_q;
  logic [N-1:0] r_b;
  logic         r_is_div;
  logic         r_neg_q;
  logic         r_neg_r;

  logic         w_signed;
  logic         w_div;
  logic [N-1:0] w_abs_a;
  logic [N-1:0] w_abs_b;
  logic [N-1:0] w_addend;
  logic [N:0]   w_sum;
  logic [N:0]   w_rem_sh;
  logic         w_ge;
  logic [N-1:0] w_sub;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_prod_fix;
  logic [N-1:0] w_quo_fix;
  logic [N-1:0] w_rem_fix;

  assign w_signed = op_is_signed(i_op);
  assign w_div    = op_is_div(i_op);

  // Magnitudes read as unsigned N-bit values, so |-2^(N-1)| = 2^(N-1) is exact.
  assign w_abs_a = (w_signed && i_src_a[N-1]) ? -i_src_a : i_src_a;
  assign w_abs_b = (w_signed && i_src_b[N-1]) ? -i_src_b : i_src_b;

  // Multiply step: add multiplicand when the current multiplier bit is set, then shift right.
  assign w_addend = r_q[0] ? r_b : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  // Divide step: shift next dividend bit into the remainder and trial-subtract the divisor.
  // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
  assign w_rem_sh = {r_acc, r_q[N-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_sub    = w_rem_sh[N-1:0] - r_b;

  // Latch operands on launch, then iterate one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_q      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_q      <= w_div ? w_abs_a : w_abs_b;
      r_b      <= w_div ? w_abs_b : w_abs_a;
      r_is_div <= w_div;
      r_neg_q  <= w_signed && (i_src_a[N-1] ^ i_src_b[N-1]);
      r_neg_r  <= w_signed && i_src_a[N-1];
    end else if (i_step) begin
      if (r_is_div) begin
        r_acc <= w_ge ? w_sub : w_rem_sh[N-1:0];
        r_q   <= {r_q[N-2:0], w_ge};
      end else begin
        r_acc <= w_sum[N:1];
        r_q   <= {w_sum[0], r_q[N-1:1]};
      end
    end
  end

  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_q ? -r_q : r_q;
  assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

  assign o_res_hi = r_is_div ? w_rem_fix : w_prod_fix[2*N-1:N];
  assign o_res_lo = r_is_div ? w_quo_fix : w_prod_fix[N-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Latency: start at edge 0 -> busy for N+1 cycles -> done pulse with new HI/LO in cycle N+2.
// Backpressure: busy stalls control; start/mthi/mtlo are dropped while busy.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input logic             clk,
  input logic             rst_n,
  mult_div_unit_if.slave  bus
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic          r_done;
  logic          w_load;
  logic          w_step;
  logic          w_fix;
  logic [N-1:0]  w_res_hi;
  logic [N-1:0]  w_res_lo;

  mdu_datapath #(.N(N)) u_datapath (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_op     (bus.op),
    .i_src_a  (bus.src_a),
    .i_src_b  (bus.src_b),
    .o_res_hi (w_res_hi),
    .o_res_lo (w_res_lo)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and per-state strobes: launch in IDLE, iterate in RUN, commit in FIX.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_count == LAST) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration counter, restarted on each launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_count <= '0;
    else if (w_load) r_count <= '0;
    else if (w_step) r_count <= r_count + CW'(1);
  end

  // HI/LO: result commit at FIX; MTHI/MTLO only in IDLE and only when no start competes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fix) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (r_state == S_IDLE && !bus.start) begin
      if (bus.mthi) r_hi <= bus.wdata;
      if (bus.mtlo) r_lo <= bus.wdata;
    end
  end

  // Done pulse in the cycle after FIX, aligned with the new HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_fix;
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model plus directed vectors with literal results.
// Latency: expects done in cycle 34 after a start sampled at edge 0.
// Backpressure: checks that start/mthi/mtlo are ignored while busy.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_div_unit_if #(.N(N)) bus();

  mult_div_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      OP_MULTU: p = {32'h0, a} * {32'h0, b};
      OP_MULT:  p = sa * sb;
      OP_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = a / b;
          r = a % b;
          p = {r, q};
        end
      end
      default: begin
        // zero divisor counts as positive: all-ones quotient negated only for a negative dividend
        if (b == 0) begin
          q = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
          p = {a, q};
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          p  = {sr[31:0], sq[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle-level model: cycles left busy, HI/LO, done.
  int          m_rem;
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem == 0) begin
        if (bus.start) begin
          m_rem  <= 33;
          m_pend <= ref_result(bus.op, bus.src_a, bus.src_b);
        end else begin
          if (bus.mthi) m_hi <= bus.wdata;
          if (bus.mtlo) m_lo <= bus.wdata;
        end
      end else begin
        if (m_rem == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
        m_rem <= m_rem - 1;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("busy", 32'(bus.busy), 32'(m_rem != 0));
    check("done", 32'(bus.done), 32'(m_done));
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
    check("rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
  end

  // Wait for done; first is the cycle number of the first falling edge observed.
  task automatic wait_done(input string name, input int first, output int cyc);
    bit found;
    found = 1'b0;
    cyc   = 0;
    for (int i = first; i <= 60; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        cyc   = i;
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no done by cycle 60", name);
    end
  endtask

  // Launch one op now, wait for done, check cycle and literal HI/LO.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(posedge clk);
    #2 bus.start = 1'b0;
    wait_done(name, 1, cyc);
    check({name, " done cycle"}, 32'(cyc), 32'd34);
    check({name, " HI"}, bus.hi, exp_hi);
    check({name, " LO"}, bus.lo, exp_lo);
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MULTU;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    bus.rd_sel = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset HI", bus.hi, 32'd0);
    check("reset LO", bus.lo, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Multiplies and divides, back to back (each next start lands in the done cycle)
    run_op("MULTU ffff*ffff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("MULT -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("MULT min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("DIV min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("DIVU 100/0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("DIV -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'h0000_0001);

    // start/mthi/mtlo while busy are dropped; operand changes have no effect
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd2;
    bus.src_b = 32'd3;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.src_a = 32'd9;
    bus.src_b = 32'd4;
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    wait_done("busy ignore", 6, cyc);
    check("busy ignore done cycle", 32'(cyc), 32'd34);
    check("busy ignore HI", bus.hi, 32'h0);
    check("busy ignore LO", bus.lo, 32'd6);

    // MTHI in IDLE, read back through rd_data
    @(posedge clk);
    #2;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_DEAD;
    @(posedge clk);
    #2;
    bus.mthi   = 1'b0;
    bus.rd_sel = 1'b1;
    @(negedge clk);
    check("mthi rd_data", bus.rd_data, 32'h0000_DEAD);
    check("mthi LO kept", bus.lo, 32'd6);

    // MTHI and MTLO together
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(posedge clk);
    #2;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    @(negedge clk);
    check("mthi+mtlo HI", bus.hi, 32'h0000_1234);
    check("mthi+mtlo LO", bus.lo, 32'h0000_1234);

    // start beats mthi in the same IDLE cycle
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.src_a = 32'd4;
    bus.src_b = 32'd4;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_5555;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    @(negedge clk);
    check("start wins HI kept", bus.hi, 32'h0000_1234);
    wait_done("start wins", 2, cyc);
    check("start wins done cycle", 32'(cyc), 32'd34);
    check("start wins HI", bus.hi, 32'h0);
    check("start wins LO", bus.lo, 32'd16);

    // Reset in the middle of a divide
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #2;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.src_a = 32'd1000;
    bus.src_b = 32'd3;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid reset busy", 32'(bus.busy), 32'd0);
    check("mid reset done", 32'(bus.done), 32'd0);
    check("mid reset HI", bus.hi, 32'h0);
    check("mid reset LO", bus.lo, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("no done after reset", 32'(bus.done), 32'd0);
    end
    run_op("DIVU 1000/3 after reset", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
